// File: rtl/l1_request_arbiter_pkg.sv
// rtl/l1_request_arbiter_pkg.sv - shared types and constants for the L1-to-L2 request arbiter
// Purpose: requester IDs, request struct, arbiter FSM states and bus widths.
// Ports: none (package).
package l1_request_arbiter_pkg;

    localparam int L1_CONNECTIONS = 4;
    localparam int L1_ID_W        = $clog2(L1_CONNECTIONS);
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int BURST_W        = 4;

    typedef enum logic [1:0] {
        L1_DCACHE = 2'd0,
        L1_DMMU   = 2'd1,
        L1_ICACHE = 2'd2,
        L1_IMMU   = 2'd3
    } l1_id_t;

    // burst_len encodes beats-1, so a single-beat request carries 0
    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic                rnw;
        logic [DATA_W/8-1:0] be;
        logic [BURST_W-1:0]  burst_len;
    } l1_arb_request_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/l1_request_arbiter_if.sv
// rtl/l1_request_arbiter_if.sv - requester and L2-side handshake bundle for the arbiter
// Purpose: groups per-requester request/write/read-routing signals and the single L2 port.
// Ports: master = arbiter side, slave = requesters plus L2 side.
interface l1_request_arbiter_if
    import l1_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ = L1_CONNECTIONS,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    l1_arb_request_t    req [NUM_REQ];
    logic [NUM_REQ-1:0] wr_valid;
    logic [NUM_REQ-1:0] wr_ready;
    logic [DATA_W-1:0]  wr_data [NUM_REQ];

    logic               l2_req_valid;
    logic               l2_req_ready;
    l1_arb_request_t    l2_req;
    logic [ID_W-1:0]    l2_req_id;
    logic               l2_wr_valid;
    logic               l2_wr_ready;
    logic [DATA_W-1:0]  l2_wr_data;
    logic               l2_rd_valid;
    logic               l2_rd_last;
    logic [ID_W-1:0]    l2_rd_id;
    logic [DATA_W-1:0]  l2_rd_data;

    logic [NUM_REQ-1:0] rd_valid;
    logic [DATA_W-1:0]  rd_data;

    modport master (
        input  req_valid, req, wr_valid, wr_data,
        input  l2_req_ready, l2_wr_ready, l2_rd_valid, l2_rd_last, l2_rd_id, l2_rd_data,
        output req_ready, wr_ready,
        output l2_req_valid, l2_req, l2_req_id, l2_wr_valid, l2_wr_data,
        output rd_valid, rd_data
    );

    modport slave (
        output req_valid, req, wr_valid, wr_data,
        output l2_req_ready, l2_wr_ready, l2_rd_valid, l2_rd_last, l2_rd_id, l2_rd_data,
        input  req_ready, wr_ready,
        input  l2_req_valid, l2_req, l2_req_id, l2_wr_valid, l2_wr_data,
        input  rd_valid, rd_data
    );

endinterface

// File: rtl/l1_rr_select.sv
// rtl/l1_rr_select.sv - rotate-priority encoder for round-robin grant
// Purpose: picks the first eligible requester at or after rr_ptr, wrapping to 0.
// Ports: eligible (in), rr_ptr (in), winner (out), found (out).
module l1_rr_select #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               found
);

    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/l1_request_arbiter.sv
// rtl/l1_request_arbiter.sv - round-robin L1-to-L2 request arbiter with write-burst lock
// Purpose: grants one L1 requester at a time onto the registered L2 request port, holds the
//          grant through a write burst, limits outstanding reads and routes read beats by ID.
// Ports: clk, rst_n (async, active low), bus (l1_request_arbiter_if.master).
module l1_request_arbiter
    import l1_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = L1_CONNECTIONS,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    l1_request_arbiter_if.master   bus
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
    l1_arb_request_t    l2_req_q, l2_req_d;
    logic [ID_W-1:0]    l2_req_id_q, l2_req_id_d;
    logic               l2_req_valid_q, l2_req_valid_d;

    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    winner;
    logic               found;
    logic               at_limit;
    logic               rd_inc;
    logic               rd_dec;
    logic               wr_beat;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [NUM_REQ-1:0] wr_ready_c;
    logic               l2_wr_valid_c;
    logic [NUM_REQ-1:0] rd_valid_c;

    assign at_limit = (out_cnt_q == CNT_W'(MAX_OUTSTANDING));

    // Reads are masked at the limit; writes never count against it.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid[i] & ~(bus.req[i].rnw & at_limit);
        end
    end

    l1_rr_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_select (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .winner   (winner),
        .found    (found)
    );

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        beat_cnt_d     = beat_cnt_q;
        l2_req_d       = l2_req_q;
        l2_req_id_d    = l2_req_id_q;
        l2_req_valid_d = l2_req_valid_q;
        req_ready_c    = '0;
        wr_ready_c     = '0;
        l2_wr_valid_c  = 1'b0;
        rd_inc         = 1'b0;
        wr_beat        = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    // Gated by rst_n so no ready pulse escapes while reset is held.
                    req_ready_c[winner] = rst_n;
                    l2_req_d            = bus.req[winner];
                    l2_req_id_d         = winner;
                    l2_req_valid_d      = 1'b1;
                    state_d             = REQ;
                end
            end
            REQ: begin
                if (bus.l2_req_ready) begin
                    l2_req_valid_d = 1'b0;
                    rr_ptr_d = (int'(l2_req_id_q) == NUM_REQ - 1) ? '0 : l2_req_id_q + 1'b1;
                    if (l2_req_q.rnw) begin
                        rd_inc  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = l2_req_q.burst_len;
                        state_d    = WDATA;
                    end
                end
            end
            WDATA: begin
                l2_wr_valid_c           = bus.wr_valid[l2_req_id_q];
                wr_ready_c[l2_req_id_q] = bus.l2_wr_ready;
                wr_beat                 = bus.wr_valid[l2_req_id_q] & bus.l2_wr_ready;
                if (wr_beat) begin
                    if (beat_cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A stray last beat at zero is flagged below and otherwise ignored.
    assign rd_dec = bus.l2_rd_valid & bus.l2_rd_last & (out_cnt_q != '0);

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({rd_inc, rd_dec})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_comb begin
        rd_valid_c = '0;
        if (bus.l2_rd_valid) begin
            rd_valid_c[bus.l2_rd_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            out_cnt_q      <= '0;
            beat_cnt_q     <= '0;
            l2_req_q       <= '0;
            l2_req_id_q    <= '0;
            l2_req_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            out_cnt_q      <= out_cnt_d;
            beat_cnt_q     <= beat_cnt_d;
            l2_req_q       <= l2_req_d;
            l2_req_id_q    <= l2_req_id_d;
            l2_req_valid_q <= l2_req_valid_d;
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus.l2_rd_valid && bus.l2_rd_last) begin
            assert (out_cnt_q != '0);
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.wr_ready     = wr_ready_c;
    assign bus.l2_req_valid = l2_req_valid_q;
    assign bus.l2_req       = l2_req_q;
    assign bus.l2_req_id    = l2_req_id_q;
    assign bus.l2_wr_valid  = l2_wr_valid_c;
    assign bus.l2_wr_data   = bus.wr_data[l2_req_id_q];
    assign bus.rd_valid     = rd_valid_c;
    assign bus.rd_data      = bus.l2_rd_data;

endmodule

// File: tb/tb_l1_request_arbiter.sv
// tb/tb_l1_request_arbiter.sv - directed self-checking bench for l1_request_arbiter
module tb_l1_request_arbiter;
    import l1_request_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   beats;

    l1_request_arbiter_if bus ();

    l1_request_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic l1_arb_request_t mk_req(input logic [31:0] addr, input logic rnw,
                                               input logic [3:0] bl);
        l1_arb_request_t r;
        r.addr      = addr;
        r.rnw       = rnw;
        r.be        = 4'hF;
        r.burst_len = bl;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_rdy;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.req_valid    = 4'hF;
        bus.wr_valid     = 4'h0;
        bus.l2_req_ready = 1'b0;
        bus.l2_wr_ready  = 1'b0;
        bus.l2_rd_valid  = 1'b0;
        bus.l2_rd_last   = 1'b0;
        bus.l2_rd_id     = '0;
        bus.l2_rd_data   = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req[i]     = mk_req(32'h1000 + 32'(i) * 32'h10, 1'b1, 4'd0);
            bus.wr_data[i] = '0;
        end

        // 1: reset holds everything quiet, DCACHE wins first after release
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 4'b0000);
        check("rst_l2_req_valid", bus.l2_req_valid, 1'b0);
        check("rst_l2_wr_valid", bus.l2_wr_valid, 1'b0);
        check("rst_wr_ready", bus.wr_ready, 4'b0000);
        #2 rst_n = 1'b1;
        #1;
        check("first_grant", bus.req_ready, 4'b0001);
        tick;
        check("first_l2_valid", bus.l2_req_valid, 1'b1);
        check("first_l2_id", bus.l2_req_id, 2'd0);
        check("first_l2_req", bus.l2_req, mk_req(32'h1000, 1'b1, 4'd0));

        // 2: round robin 0,1,2,3,0 with immediate responses
        bus.l2_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % 4;
            check("rr_l2_id", bus.l2_req_id, 64'(e));
            check("rr_l2_valid", bus.l2_req_valid, 1'b1);
            tick;
            bus.l2_rd_valid = 1'b1;
            bus.l2_rd_last  = 1'b1;
            bus.l2_rd_id    = 2'(e);
            if (k == 4) bus.req_valid = 4'h0;
            #1;
            check("rr_route", bus.rd_valid, 64'(4'b0001 << e));
            exp_rdy = (k < 4) ? 4'(4'b0001 << ((e + 1) % 4)) : 4'b0000;
            check("rr_next_grant", bus.req_ready, 64'(exp_rdy));
            tick;
            bus.l2_rd_valid = 1'b0;
            bus.l2_rd_last  = 1'b0;
        end
        bus.l2_req_ready = 1'b0;

        // 3: DCACHE write burst of 4 beats, IMMU read waits for the lock to clear
        bus.req[0]    = mk_req(32'h2000, 1'b0, 4'd3);
        bus.req_valid = 4'b0001;
        #1;
        check("wr_grant", bus.req_ready, 4'b0001);
        tick;
        bus.req_valid = 4'b1000;
        bus.req[3]    = mk_req(32'h3000, 1'b1, 4'd0);
        #1;
        check("wr_l2_req", bus.l2_req, mk_req(32'h2000, 1'b0, 4'd3));
        check("wr_lock_req", bus.req_ready, 4'b0000);
        bus.l2_req_ready = 1'b1;
        tick;
        bus.l2_req_ready = 1'b0;
        bus.wr_valid = 4'b0001;
        beats = 0;
        for (int c = 0; c < 7; c++) begin
            bus.l2_wr_ready = (c % 2 == 0);
            bus.wr_data[0]  = 32'hA000_0000 + 32'(beats);
            #1;
            check("wr_l2_valid", bus.l2_wr_valid, 1'b1);
            check("wr_l2_data", bus.l2_wr_data, 32'hA000_0000 + 32'(beats));
            check("wr_ready", bus.wr_ready, (c % 2 == 0) ? 4'b0001 : 4'b0000);
            check("wr_immu_blocked", bus.req_ready, 4'b0000);
            if (c % 2 == 0) beats++;
            tick;
        end
        bus.wr_valid    = 4'h0;
        bus.l2_wr_ready = 1'b0;
        #1;
        check("wr_done_quiet", bus.l2_wr_valid, 1'b0);
        check("immu_grant", bus.req_ready, 4'b1000);
        tick;
        check("immu_l2_id", bus.l2_req_id, 2'd3);
        bus.l2_req_ready = 1'b1;
        tick;
        bus.l2_req_ready = 1'b0;
        bus.req_valid    = 4'h0;
        bus.l2_rd_valid  = 1'b1;
        bus.l2_rd_last   = 1'b1;
        bus.l2_rd_id     = 2'd3;
        #1;
        check("immu_route", bus.rd_valid, 4'b1000);
        tick;
        bus.l2_rd_valid = 1'b0;
        bus.l2_rd_last  = 1'b0;

        // 4: four reads fill the outstanding budget
        bus.req[0]    = mk_req(32'h4000, 1'b1, 4'd0);
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("lim_fill_grant", bus.req_ready, 4'b0001);
            tick;
            bus.l2_req_ready = 1'b1;
            tick;
            bus.l2_req_ready = 1'b0;
        end
        bus.req[2]    = mk_req(32'h5000, 1'b1, 4'd0);
        bus.req_valid = 4'b0100;
        #1;
        check("lim_block", bus.req_ready, 4'b0000);
        tick;
        check("lim_block_hold", bus.req_ready, 4'b0000);
        check("lim_no_l2_valid", bus.l2_req_valid, 1'b0);

        // write still proceeds at the limit
        bus.req[1]    = mk_req(32'h6000, 1'b0, 4'd0);
        bus.req_valid = 4'b0110;
        #1;
        check("lim_write_grant", bus.req_ready, 4'b0010);
        tick;
        bus.req_valid = 4'b0100;
        check("lim_write_id", bus.l2_req_id, 2'd1);
        bus.l2_req_ready = 1'b1;
        tick;
        bus.l2_req_ready = 1'b0;
        bus.wr_valid     = 4'b0010;
        bus.wr_data[1]   = 32'h5A5A_0001;
        bus.l2_wr_ready  = 1'b1;
        #1;
        check("lim_write_beat", bus.l2_wr_valid, 1'b1);
        check("lim_write_ready", bus.wr_ready, 4'b0010);
        check("lim_write_data", bus.l2_wr_data, 32'h5A5A_0001);
        tick;
        bus.wr_valid    = 4'h0;
        bus.l2_wr_ready = 1'b0;
        #1;
        check("lim_still_block", bus.req_ready, 4'b0000);

        // 5: two-beat read routed to ICACHE, last beat frees a slot
        bus.l2_rd_valid = 1'b1;
        bus.l2_rd_id    = 2'd2;
        bus.l2_rd_last  = 1'b0;
        bus.l2_rd_data  = 32'hDEAD_0001;
        #1;
        check("route_b1_valid", bus.rd_valid, 4'b0100);
        check("route_b1_data", bus.rd_data, 32'hDEAD_0001);
        check("route_b1_block", bus.req_ready, 4'b0000);
        tick;
        bus.l2_rd_last = 1'b1;
        bus.l2_rd_data = 32'hDEAD_0002;
        #1;
        check("route_b2_valid", bus.rd_valid, 4'b0100);
        check("route_b2_data", bus.rd_data, 32'hDEAD_0002);
        check("route_b2_block", bus.req_ready, 4'b0000);
        tick;
        bus.l2_rd_valid = 1'b0;
        bus.l2_rd_last  = 1'b0;
        #1;
        check("lim_release_grant", bus.req_ready, 4'b0100);
        bus.req_valid = 4'h0;
        tick;
        bus.l2_rd_valid = 1'b1;
        bus.l2_rd_last  = 1'b1;
        bus.l2_rd_id    = 2'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("drain_route", bus.rd_valid, 4'b0001);
            tick;
        end
        bus.l2_rd_valid = 1'b0;
        bus.l2_rd_last  = 1'b0;

        // 6: async reset after the first of four write beats
        bus.req[0]    = mk_req(32'h7000, 1'b0, 4'd3);
        bus.req_valid = 4'b0001;
        #1;
        check("rst6_grant", bus.req_ready, 4'b0001);
        tick;
        bus.req_valid    = 4'h0;
        bus.l2_req_ready = 1'b1;
        tick;
        bus.l2_req_ready = 1'b0;
        bus.wr_valid     = 4'b0001;
        bus.wr_data[0]   = 32'hB000_0000;
        bus.l2_wr_ready  = 1'b1;
        #1;
        check("rst6_beat1", bus.l2_wr_valid, 1'b1);
        tick;
        #2 rst_n = 1'b0;
        #1;
        check("rst6_wr_valid", bus.l2_wr_valid, 1'b0);
        check("rst6_wr_ready", bus.wr_ready, 4'b0000);
        check("rst6_l2_req_valid", bus.l2_req_valid, 1'b0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("rst6_no_beat", bus.l2_wr_valid, 1'b0);
            check("rst6_no_ready", bus.wr_ready, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
